// File: rtl/fetch_unit_pkg.sv
// Shared core constants for the fetch front end.
//   XLEN_DEF     : default address / PC width
//   ILEN_DEF     : default instruction word width
//   RESET_PC_DEF : default first PC fetched after reset
//   INST_STEP    : byte distance between consecutive instructions
package fetch_unit_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam int unsigned INST_STEP    = 4;

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Registered instruction queue: DEPTH entries of WIDTH bits.
//   clk, reset : clock, asynchronous active-low reset
//   push_i     : write data_i at the tail (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : empty the queue; a same-cycle push or pop has no effect
//   data_i     : entry to push
//   data_o     : head entry (meaningful only when count_o != 0)
//   count_o    : number of valid entries
// No write-to-read bypass: a pushed entry shows up at data_o one cycle later.
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i && !flush_i && (count_q != FULL);
  assign do_pop  = pop_i  && !flush_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
//   clk, reset           : clock, asynchronous active-low reset
//   imem_req_valid/ready : in-order fetch request handshake, imem_req_addr = fetch PC
//   imem_rsp_valid/data  : in-order response words from instruction memory
//   redirect_valid/pc    : execute redirect; flushes queue and stale responses
//   inst_valid/ready     : queue head handshake toward decode
//   inst_data, inst_pc   : head instruction and its PC
// Credit rule: requests are issued only while in-flight + queued < DEPTH, so
// every response always has a free queue slot.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned   CW         = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CAP        = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP     = XLEN'(INST_STEP);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credits_used;
  logic            accept, rsp_push, fifo_pop;
  logic [XLEN-1:0] redirect_target;

  assign credits_used    = {1'b0, inflight_q} + {1'b0, fifo_count};
  // Gated by reset so the request drops the moment reset asserts.
  assign imem_req_valid  = reset && !redirect_valid && (credits_used < CAP);
  assign imem_req_addr   = fetch_pc_q;
  assign accept          = imem_req_valid && imem_req_ready;
  assign rsp_push        = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign redirect_target = redirect_pc & ~LOW_MASK;
  assign fifo_pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid      = (fifo_count != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q;
    if (accept)         inflight_d = inflight_d + 1'b1;
    if (imem_rsp_valid) inflight_d = inflight_d - 1'b1;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      // Everything still outstanding after this edge belongs to the old path.
      drop_d     = inflight_d;
    end else begin
      if (accept)   fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_push) rsp_pc_d   = rsp_pc_q + STEP;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_inst_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .data_i  ({rsp_pc_q, imem_rsp_data}),
    .data_o  ({inst_pc, inst_data}),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  fetch_unit #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .DEPTH    (DEPTH),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  logic [63:0] got_pc[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;
  int n_acc;
  int bad_acc8 = 0;
  int stale;
  bit watch8 = 1'b0;

  logic        s_acc, s_rsp, s_req_valid, s_inst_valid;
  logic [63:0] s_addr, s_inst_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory drives its response, combinational outputs are
  // sampled mid-cycle, scoreboard is updated, then the clock edge is taken.
  task automatic tick();
    exp_t e;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    s_req_valid  = imem_req_valid;
    s_addr       = imem_req_addr;
    s_acc        = imem_req_valid && imem_req_ready;
    s_rsp        = imem_rsp_valid;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    if (s_rsp) memq.delete(0);
    if (redirect_valid) begin
      expq.delete();
    end else if (inst_valid && inst_ready) begin
      chk("sb_nonempty", 64'(expq.size() != 0), 64'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_data", 64'(inst_data), 64'(e.data));
      end
      got_pc.push_back(inst_pc);
    end
    if (s_acc) begin
      memq.push_back('{addr: imem_req_addr, due: cyc + lat});
      expq.push_back('{pc: imem_req_addr, data: mem_word(imem_req_addr)});
      if (watch8 && imem_req_addr == 64'h8) bad_acc8++;
    end
    chk("credit_cap", 64'(expq.size() <= DEPTH), 64'd1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    memq.delete();
    expq.delete();
    got_pc.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #2;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: streaming with 1-cycle memory
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_acc", 64'(s_acc), 64'd1);
      chk("t1_addr", s_addr, 64'(4 * i));
      if (i < 2) begin
        chk("t1_valid_early", 64'(s_inst_valid), 64'd0);
      end else begin
        chk("t1_valid", 64'(s_inst_valid), 64'd1);
        chk("t1_pc", s_inst_pc, 64'(4 * (i - 2)));
      end
    end
    imem_req_ready = 1'b0;
    repeat (4) tick();
    chk("t1_drained", 64'(expq.size()), 64'd0);

    // 2: credit limit with decode stalled
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    n_acc = 0;
    repeat (10) begin
      tick();
      if (s_acc) n_acc++;
    end
    chk("t2_accepts", 64'(n_acc), 64'd4);
    chk("t2_req_blocked", 64'(s_req_valid), 64'd0);
    inst_ready = 1'b1;
    tick();
    chk("t2_pop_pc", s_inst_pc, 64'h0);
    inst_ready = 1'b0;
    n_acc = 0;
    repeat (6) begin
      tick();
      if (s_acc) n_acc++;
    end
    chk("t2_one_more", 64'(n_acc), 64'd1);
    chk("t2_req_blocked2", 64'(s_req_valid), 64'd0);
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    repeat (6) tick();
    chk("t2_drained", 64'(expq.size()), 64'd0);

    // 3: redirect with 3 requests in flight, 3-cycle memory
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (3) tick();
    chk("t3_inflight", 64'(memq.size()), 64'd3);
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    tick();
    chk("t3_redir_req_low", 64'(s_req_valid), 64'd0);
    redirect_valid = 1'b0;
    got_pc.delete();
    tick();
    chk("t3_new_acc", 64'(s_acc), 64'd1);
    chk("t3_new_addr", s_addr, 64'h100);
    repeat (10) tick();
    chk("t3_npop", 64'(got_pc.size() >= 2), 64'd1);
    if (got_pc.size() >= 2) begin
      chk("t3_first_pc", got_pc[0], 64'h100);
      chk("t3_second_pc", got_pc[1], 64'h104);
    end

    // 4: redirect coinciding with a response and a pop
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    tick();
    chk("t4_rsp_in_redir", 64'(s_rsp), 64'd1);
    chk("t4_pop_in_redir", 64'(s_inst_valid), 64'd1);
    redirect_valid = 1'b0;
    got_pc.delete();
    tick();
    chk("t4_valid_n1", 64'(s_inst_valid), 64'd0);
    chk("t4_addr_n1", s_addr, 64'h40);
    tick();
    chk("t4_valid_n2", 64'(s_inst_valid), 64'd0);
    tick();
    chk("t4_valid_n3", 64'(s_inst_valid), 64'd1);
    chk("t4_pc_n3", s_inst_pc, 64'h40);
    repeat (4) tick();
    stale = 0;
    foreach (got_pc[k]) if (got_pc[k] < 64'h40) stale++;
    chk("t4_no_stale", 64'(stale), 64'd0);
    chk("t4_delivered", 64'(got_pc.size() >= 4), 64'd1);

    // 5: memory stall, then misaligned redirect during the stall
    do_reset();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (2) tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 64'(s_req_valid), 64'd1);
      chk("t5_hold_addr", s_addr, 64'h8);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h203;
    tick();
    chk("t5_redir_req_low", 64'(s_req_valid), 64'd0);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    watch8 = 1'b1; bad_acc8 = 0;
    tick();
    chk("t5_new_acc", 64'(s_acc), 64'd1);
    chk("t5_new_addr", s_addr, 64'h200);
    repeat (6) tick();
    chk("t5_no_addr8", 64'(bad_acc8), 64'd0);
    watch8 = 1'b0;

    // 6: asynchronous reset with queued words and requests in flight
    do_reset();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (5) tick();
    chk("t6_inflight", 64'(memq.size()), 64'd2);
    chk("t6_valid_before", 64'(inst_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t6_rst_inst_valid", 64'(inst_valid), 64'd0);
    memq.delete();
    expq.delete();
    got_pc.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    lat = 1; inst_ready = 1'b1;
    tick();
    chk("t6_restart_acc", 64'(s_acc), 64'd1);
    chk("t6_restart_addr", s_addr, 64'h0);
    repeat (4) tick();
    chk("t6_npop", 64'(got_pc.size() >= 1), 64'd1);
    if (got_pc.size() >= 1) chk("t6_first_pc", got_pc[0], 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
